redirect_ctrl: RTL and testbench

//  Branch-redirect generator for the four-issue front end; it drives the flush logic with per-lane redirect sources.

---
 rtl/redirect_ctrl.sv | 157 +++++++++++++++
 tb/tb_redirect_ctrl.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/redirect_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : redirect_ctrl                                                |
// | Description : Branch-redirect generator for a four-issue front end. Finds  |
// |               the oldest taken branch/jump in a decoded 4-wide group and   |
// |               honours the MIPS delay slot. Produces per-lane kill masks    |
// |               for wrong-path lanes and a single registered PC redirect.    |
// |               A pending redirect is held across fetch stalls.              |
// | Ports       : clk, reset        - clock / async active-high reset          |
// |               grp_valid         - a decoded 4-lane group is presented      |
// |               br_taken[3:0]     - per-lane taken, lane 0 is oldest         |
// |               br_target         - per-lane targets, lane i at [i*PC_W+:]   |
// |               fetch_stall       - fetch cannot accept a redirect           |
// |               exc_flush         - exception flush, highest priority        |
// |               lane_kill[3:0]    - combinational kill mask for this group   |
// |               redir_valid       - one-cycle redirect pulse                 |
// |               redir_pc          - redirect target, valid with redir_valid  |
// |               busy              - controller not idle                      |
// |               redir_cnt         - saturating count of issued redirects     |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module redirect_ctrl #(
  parameter int PC_W  = 32,
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              grp_valid,
  input  logic [3:0]        br_taken,
  input  logic [4*PC_W-1:0] br_target,
  input  logic              fetch_stall,
  input  logic              exc_flush,
  output logic [3:0]        lane_kill,
  output logic              redir_valid,
  output logic [PC_W-1:0]   redir_pc,
  output logic              busy,
  output logic [CNT_W-1:0]  redir_cnt
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_DS = 2'd1,
    HOLD    = 2'd2,
    REDIR   = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] C_CNT_MAX = {CNT_W{1'b1}};

  state_t            state_q, state_d;
  logic [PC_W-1:0]   pend_pc_q, pend_pc_d;
  logic              redir_valid_q, redir_valid_d;
  logic [PC_W-1:0]   redir_pc_q, redir_pc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic              taken_any;
  logic [1:0]        k;
  logic [PC_W-1:0]   tgt_k;
  logic [3:0]        kill_k;

  // Oldest taken lane wins; younger taken lanes are on the wrong path anyway.
  always_comb begin
    taken_any = |br_taken;
    k         = 2'd0;
    casez (br_taken)
      4'b???1: k = 2'd0;
      4'b??10: k = 2'd1;
      4'b?100: k = 2'd2;
      4'b1000: k = 2'd3;
      default: k = 2'd0;
    endcase
  end

  // Target of the winning lane and the lanes beyond its delay slot (k+2..3).
  always_comb begin
    tgt_k  = br_target[0 +: PC_W];
    kill_k = 4'b0000;
    case (k)
      2'd0: begin tgt_k = br_target[0*PC_W +: PC_W]; kill_k = 4'b1100; end
      2'd1: begin tgt_k = br_target[1*PC_W +: PC_W]; kill_k = 4'b1000; end
      2'd2: begin tgt_k = br_target[2*PC_W +: PC_W]; kill_k = 4'b0000; end
      default: begin tgt_k = br_target[3*PC_W +: PC_W]; kill_k = 4'b0000; end
    endcase
  end

  always_comb begin
    state_d   = state_q;
    pend_pc_d = pend_pc_q;
    cnt_d     = cnt_q;
    lane_kill = 4'b0000;

    case (state_q)
      IDLE: begin
        if (grp_valid && taken_any) begin
          pend_pc_d = tgt_k;
          if (k == 2'd3) begin
            // Delay slot lives in the next group; nothing to kill yet.
            state_d = WAIT_DS;
          end else begin
            lane_kill = kill_k;
            state_d   = fetch_stall ? HOLD : REDIR;
          end
        end
      end
      WAIT_DS: begin
        if (grp_valid) begin
          // Lane 0 is the delay slot; branches in this group are ignored.
          lane_kill = 4'b1110;
          state_d   = fetch_stall ? HOLD : REDIR;
        end
      end
      HOLD: begin
        if (grp_valid) lane_kill = 4'b1111;
        if (!fetch_stall) state_d = REDIR;
      end
      REDIR: begin
        if (grp_valid) lane_kill = 4'b1111;
        state_d = IDLE;
        if (cnt_q != C_CNT_MAX) cnt_d = cnt_q + CNT_W'(1);
      end
      default: state_d = IDLE;
    endcase

    if (exc_flush) begin
      lane_kill = 4'b1111;
      state_d   = IDLE;
      cnt_d     = cnt_q;
    end

    // Pulse and target are registered on entry to REDIR so they line up with it.
    redir_valid_d = (state_d == REDIR);
    redir_pc_d    = (state_d == REDIR) ? pend_pc_d : redir_pc_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      pend_pc_q     <= '0;
      redir_valid_q <= 1'b0;
      redir_pc_q    <= '0;
      cnt_q         <= '0;
    end else begin
      state_q       <= state_d;
      pend_pc_q     <= pend_pc_d;
      redir_valid_q <= redir_valid_d;
      redir_pc_q    <= redir_pc_d;
      cnt_q         <= cnt_d;
    end
  end

  // An exception arriving during the REDIR cycle cancels the pulse outright.
  assign redir_valid = redir_valid_q & ~exc_flush;
  assign redir_pc    = redir_pc_q;
  assign busy        = (state_q != IDLE);
  assign redir_cnt   = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_redirect_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_redirect_ctrl                                             |
// | Description : Directed self-checking bench for redirect_ctrl.              |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module tb_redirect_ctrl;

  localparam int PC_W  = 32;
  localparam int CNT_W = 4;

  logic              clk;
  logic              reset;
  logic              grp_valid;
  logic [3:0]        br_taken;
  logic [4*PC_W-1:0] br_target;
  logic              fetch_stall;
  logic              exc_flush;
  logic [3:0]        lane_kill;
  logic              redir_valid;
  logic [PC_W-1:0]   redir_pc;
  logic              busy;
  logic [CNT_W-1:0]  redir_cnt;

  int checks;
  int errors;

  redirect_ctrl #(.PC_W(PC_W), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .reset       (reset),
    .grp_valid   (grp_valid),
    .br_taken    (br_taken),
    .br_target   (br_target),
    .fetch_stall (fetch_stall),
    .exc_flush   (exc_flush),
    .lane_kill   (lane_kill),
    .redir_valid (redir_valid),
    .redir_pc    (redir_pc),
    .busy        (busy),
    .redir_cnt   (redir_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_tgt(input int lane, input logic [PC_W-1:0] pc);
    br_target[lane*PC_W +: PC_W] = pc;
  endtask

  // Apply inputs just after a rising edge and let them settle before checks.
  task automatic step(input logic gv, input logic [3:0] tk, input logic st, input logic ex);
    @(posedge clk);
    #1;
    grp_valid   = gv;
    br_taken    = tk;
    fetch_stall = st;
    exc_flush   = ex;
    #1;
  endtask

  initial begin
    checks      = 0;
    errors      = 0;
    reset       = 1'b1;
    grp_valid   = 1'b0;
    br_taken    = 4'b0000;
    br_target   = '0;
    fetch_stall = 1'b0;
    exc_flush   = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    check("rst_valid", {31'd0, redir_valid}, 32'd0);
    check("rst_pc",    redir_pc, 32'd0);
    check("rst_cnt",   {28'd0, redir_cnt}, 32'd0);
    check("rst_busy",  {31'd0, busy}, 32'd0);
    check("rst_kill",  {28'd0, lane_kill}, 32'd0);
    reset = 1'b0;

    // T1: lane 1 taken, no stall
    set_tgt(1, 32'h0040_0100);
    step(1'b1, 4'b0010, 1'b0, 1'b0);
    check("t1_kill", {28'd0, lane_kill}, 32'h8);
    step(1'b0, 4'b0000, 1'b0, 1'b0);
    check("t1_valid", {31'd0, redir_valid}, 32'd1);
    check("t1_pc",    redir_pc, 32'h0040_0100);
    step(1'b0, 4'b0000, 1'b0, 1'b0);
    check("t1_valid_off", {31'd0, redir_valid}, 32'd0);
    check("t1_cnt",   {28'd0, redir_cnt}, 32'd1);
    check("t1_busy",  {31'd0, busy}, 32'd0);

    // T2: lane 3 taken, delay slot in next group
    set_tgt(3, 32'h0040_0200);
    step(1'b1, 4'b1000, 1'b0, 1'b0);
    check("t2_kill_a", {28'd0, lane_kill}, 32'h0);
    step(1'b1, 4'b0001, 1'b0, 1'b0);
    check("t2_kill_b", {28'd0, lane_kill}, 32'hE);
    check("t2_busy",   {31'd0, busy}, 32'd1);
    check("t2_nopulse", {31'd0, redir_valid}, 32'd0);
    step(1'b0, 4'b0000, 1'b0, 1'b0);
    check("t2_valid", {31'd0, redir_valid}, 32'd1);
    check("t2_pc",    redir_pc, 32'h0040_0200);
    step(1'b0, 4'b0000, 1'b0, 1'b0);
    check("t2_cnt",   {28'd0, redir_cnt}, 32'd2);

    // T3: lane 0 taken with fetch stalled for 3 cycles
    set_tgt(0, 32'h0040_0300);
    step(1'b1, 4'b0001, 1'b1, 1'b0);
    check("t3_kill_0", {28'd0, lane_kill}, 32'hC);
    for (int i = 0; i < 2; i++) begin
      step(1'b1, 4'b0000, 1'b1, 1'b0);
      check("t3_hold_kill",  {28'd0, lane_kill}, 32'hF);
      check("t3_hold_valid", {31'd0, redir_valid}, 32'd0);
    end
    step(1'b1, 4'b0010, 1'b0, 1'b0);
    check("t3_release_kill",  {28'd0, lane_kill}, 32'hF);
    check("t3_release_valid", {31'd0, redir_valid}, 32'd0);
    step(1'b0, 4'b0000, 1'b0, 1'b0);
    check("t3_valid", {31'd0, redir_valid}, 32'd1);
    check("t3_pc",    redir_pc, 32'h0040_0300);
    step(1'b0, 4'b0000, 1'b0, 1'b0);
    check("t3_cnt",   {28'd0, redir_cnt}, 32'd3);

    // T4: oldest of two taken lanes wins; k=2 kills nothing
    set_tgt(0, 32'h0040_0400);
    set_tgt(2, 32'h0040_0402);
    step(1'b1, 4'b0101, 1'b0, 1'b0);
    check("t4_kill_a", {28'd0, lane_kill}, 32'hC);
    step(1'b0, 4'b0000, 1'b0, 1'b0);
    check("t4_pc_a",   redir_pc, 32'h0040_0400);
    set_tgt(2, 32'h0040_0500);
    step(1'b1, 4'b0100, 1'b0, 1'b0);
    check("t4_kill_b", {28'd0, lane_kill}, 32'h0);
    step(1'b0, 4'b0000, 1'b0, 1'b0);
    check("t4_valid_b", {31'd0, redir_valid}, 32'd1);
    check("t4_pc_b",   redir_pc, 32'h0040_0500);
    step(1'b0, 4'b0000, 1'b0, 1'b0);
    check("t4_cnt",    {28'd0, redir_cnt}, 32'd5);

    // T5a: exception while waiting for the delay slot
    set_tgt(3, 32'h0040_0600);
    step(1'b1, 4'b1000, 1'b0, 1'b0);
    step(1'b1, 4'b0000, 1'b0, 1'b1);
    check("t5_ds_kill", {28'd0, lane_kill}, 32'hF);
    step(1'b0, 4'b0000, 1'b0, 1'b0);
    check("t5_ds_valid", {31'd0, redir_valid}, 32'd0);
    check("t5_ds_busy",  {31'd0, busy}, 32'd0);
    step(1'b0, 4'b0000, 1'b0, 1'b0);
    check("t5_ds_cnt",   {28'd0, redir_cnt}, 32'd5);

    // T5b: exception in the REDIR cycle cancels the pulse
    set_tgt(1, 32'h0040_0700);
    step(1'b1, 4'b0010, 1'b0, 1'b0);
    check("t5_r_kill_a", {28'd0, lane_kill}, 32'h8);
    step(1'b0, 4'b0000, 1'b0, 1'b1);
    check("t5_r_valid", {31'd0, redir_valid}, 32'd0);
    check("t5_r_kill",  {28'd0, lane_kill}, 32'hF);
    step(1'b0, 4'b0000, 1'b0, 1'b0);
    check("t5_r_busy",  {31'd0, busy}, 32'd0);
    check("t5_r_valid2", {31'd0, redir_valid}, 32'd0);
    check("t5_r_cnt",   {28'd0, redir_cnt}, 32'd5);

    // T5c: async reset while holding
    set_tgt(0, 32'h0040_0800);
    step(1'b1, 4'b0001, 1'b1, 1'b0);
    step(1'b1, 4'b0000, 1'b1, 1'b0);
    check("t5_hold_busy", {31'd0, busy}, 32'd1);
    #1;
    reset = 1'b1;
    #1;
    check("t5_rst_busy",  {31'd0, busy}, 32'd0);
    check("t5_rst_valid", {31'd0, redir_valid}, 32'd0);
    check("t5_rst_pc",    redir_pc, 32'd0);
    check("t5_rst_cnt",   {28'd0, redir_cnt}, 32'd0);
    grp_valid   = 1'b0;
    fetch_stall = 1'b0;
    #1;
    reset = 1'b0;
    step(1'b0, 4'b0000, 1'b0, 1'b0);
    check("t5_post_valid", {31'd0, redir_valid}, 32'd0);
    step(1'b0, 4'b0000, 1'b0, 1'b0);
    check("t5_post_valid2", {31'd0, redir_valid}, 32'd0);
    check("t5_post_busy",   {31'd0, busy}, 32'd0);

    // T6: 20 redirects saturate the 4-bit counter at 0xF
    set_tgt(1, 32'h0040_0900);
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 4'b0010, 1'b0, 1'b0);
      check("t6_cnt_run", {28'd0, redir_cnt}, (i < 15) ? i : 15);
      step(1'b0, 4'b0000, 1'b0, 1'b0);
      check("t6_pulse", {31'd0, redir_valid}, 32'd1);
    end
    step(1'b0, 4'b0000, 1'b0, 1'b0);
    check("t6_cnt_sat", {28'd0, redir_cnt}, 32'hF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
